// File: rtl/rejestry_alu.sv
// Register file with a per-register load/increment/decrement/clear unit.
// The file has two combinational read ports and one write port.
// Zero and carry flags record the result of the last operation that executed.
module rejestry_alu #(
   parameter int Rx_liczba = 8,
   parameter int SZER      = 8,
   parameter int ZERO_R0   = 0,
   localparam int AW       = (Rx_liczba > 2) ? $clog2(Rx_liczba) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_Rx,
   input  logic [AW-1:0]   nr_Rx,
   input  logic [1:0]      tryb,
   input  logic [SZER-1:0] dane,
   input  logic [AW-1:0]   nr_A,
   input  logic [AW-1:0]   nr_B,
   output logic [SZER-1:0] out_A,
   output logic [SZER-1:0] out_B,
   output logic            flaga_Z,
   output logic            flaga_C
);

   // Register count widened by one bit so numbers >= Rx_liczba can be detected
   localparam logic [AW:0] NUM_W = (AW+1)'(Rx_liczba);

   localparam logic [1:0] TRYB_LOAD = 2'b00;
   localparam logic [1:0] TRYB_INC  = 2'b01;
   localparam logic [1:0] TRYB_DEC  = 2'b10;
   localparam logic [1:0] TRYB_CLR  = 2'b11;

   logic [SZER-1:0] r_rx [Rx_liczba];
   logic            r_flaga_z;
   logic            r_flaga_c;

   logic            w_a_ok;
   logic            w_b_ok;
   logic            w_dst_ok;
   logic            w_exec;
   logic [SZER-1:0] w_old;
   logic [SZER:0]   w_inc;
   logic [SZER:0]   w_dec;
   logic [SZER-1:0] w_result;
   logic            w_carry;

   // Read ports: out-of-range numbers and a hardwired R0 read as zero
   always_comb begin
      w_a_ok = ({1'b0, nr_A} < NUM_W) && !((ZERO_R0 != 0) && (nr_A == '0));
      w_b_ok = ({1'b0, nr_B} < NUM_W) && !((ZERO_R0 != 0) && (nr_B == '0));
      out_A  = w_a_ok ? r_rx[nr_A] : '0;
      out_B  = w_b_ok ? r_rx[nr_B] : '0;
   end

   // Operation unit: result and carry/borrow computed from the destination's current value
   always_comb begin
      w_dst_ok = ({1'b0, nr_Rx} < NUM_W) && !((ZERO_R0 != 0) && (nr_Rx == '0));
      w_exec   = wr_Rx && w_dst_ok;
      w_old    = w_dst_ok ? r_rx[nr_Rx] : '0;
      w_inc    = {1'b0, w_old} + (SZER+1)'(1);
      w_dec    = {1'b0, w_old} - (SZER+1)'(1);
      w_result = '0;
      w_carry  = 1'b0;
      case (tryb)
         TRYB_LOAD: begin
            w_result = dane;
            w_carry  = 1'b0;
         end
         TRYB_INC: begin
            w_result = w_inc[SZER-1:0];
            w_carry  = w_inc[SZER];
         end
         TRYB_DEC: begin
            // The extra top bit goes high only when the register was zero, so it is the borrow
            w_result = w_dec[SZER-1:0];
            w_carry  = w_dec[SZER];
         end
         TRYB_CLR: begin
            w_result = '0;
            w_carry  = 1'b0;
         end
         default: begin
            w_result = '0;
            w_carry  = 1'b0;
         end
      endcase
   end

   // Register array update; reset takes priority over any pending operation
   always_ff @(posedge clk) begin
      for (int i = 0; i < Rx_liczba; i++) begin
         if (rst) begin
            r_rx[i] <= '0;
         end else if (w_exec && (nr_Rx == AW'(i))) begin
            r_rx[i] <= w_result;
         end
      end
   end

   // Flags change only on edges where an operation actually executes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flaga_z <= 1'b0;
         r_flaga_c <= 1'b0;
      end else if (w_exec) begin
         r_flaga_z <= (w_result == '0);
         r_flaga_c <= w_carry;
      end
   end

   assign flaga_Z = r_flaga_z;
   assign flaga_C = r_flaga_c;

endmodule

// File: tb/tb_rejestry_alu.sv
// Bench for rejestry_alu. Two instances share one stimulus bus:
// dut0 uses the default 8 x 8-bit register file.
// dut1 is a 6-register build with R0 hardwired to zero.
// A plain-arithmetic model of each instance predicts the outputs.
module tb_rejestry_alu;

   logic       clk;
   logic       rst;
   logic       wr_Rx;
   logic [2:0] nr_Rx;
   logic [1:0] tryb;
   logic [7:0] dane;
   logic [2:0] nr_A;
   logic [2:0] nr_B;
   logic [7:0] out_A0, out_B0, out_A1, out_B1;
   logic       z0, c0, z1, c1;

   int total = 0;
   int bad   = 0;

   // Reference state: register contents as plain ints, plus the flags
   int m0 [8];
   int m1 [6];
   int mz0, mc0, mz1, mc1;

   rejestry_alu #(.Rx_liczba(8), .SZER(8), .ZERO_R0(0)) dut0 (
      .clk(clk), .rst(rst), .wr_Rx(wr_Rx), .nr_Rx(nr_Rx), .tryb(tryb), .dane(dane),
      .nr_A(nr_A), .nr_B(nr_B), .out_A(out_A0), .out_B(out_B0),
      .flaga_Z(z0), .flaga_C(c0)
   );

   rejestry_alu #(.Rx_liczba(6), .SZER(8), .ZERO_R0(1)) dut1 (
      .clk(clk), .rst(rst), .wr_Rx(wr_Rx), .nr_Rx(nr_Rx), .tryb(tryb), .dane(dane),
      .nr_A(nr_A), .nr_B(nr_B), .out_A(out_A1), .out_B(out_B1),
      .flaga_Z(z1), .flaga_C(c1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rd0(input int n);
      return m0[n];
   endfunction

   function automatic int rd1(input int n);
      if (n == 0 || n >= 6) return 0;
      return m1[n];
   endfunction

   // Apply one operation to a register value: returns the new value and the carry
   function automatic void model_op(input int v, input int t, input int d,
                                    output int res, output int cy);
      case (t)
         0: begin res = d; cy = 0; end
         1: begin res = (v + 1) % 256; cy = (v == 255) ? 1 : 0; end
         2: begin res = (v + 255) % 256; cy = (v == 0) ? 1 : 0; end
         default: begin res = 0; cy = 0; end
      endcase
   endfunction

   // One clock cycle: drive the inputs, check the reads before the edge, then
   // advance the models and check the flags and reads after the edge
   task automatic step(input int rv, input int wv, input int nr, input int t,
                       input int d, input int na, input int nb);
      int res, cy;
      rst   = rv[0];
      wr_Rx = wv[0];
      nr_Rx = nr[2:0];
      tryb  = t[1:0];
      dane  = d[7:0];
      nr_A  = na[2:0];
      nr_B  = nb[2:0];
      #2;
      check("pre_A0", 32'(out_A0), 32'(rd0(na)));
      check("pre_B0", 32'(out_B0), 32'(rd0(nb)));
      check("pre_A1", 32'(out_A1), 32'(rd1(na)));
      check("pre_B1", 32'(out_B1), 32'(rd1(nb)));
      @(posedge clk);
      #1;
      if (rv != 0) begin
         foreach (m0[i]) m0[i] = 0;
         foreach (m1[i]) m1[i] = 0;
         mz0 = 0; mc0 = 0; mz1 = 0; mc1 = 0;
      end else if (wv != 0) begin
         model_op(m0[nr], t, d, res, cy);
         m0[nr] = res;
         mz0 = (res == 0) ? 1 : 0;
         mc0 = cy;
         if (nr != 0 && nr < 6) begin
            model_op(m1[nr], t, d, res, cy);
            m1[nr] = res;
            mz1 = (res == 0) ? 1 : 0;
            mc1 = cy;
         end
      end
      check("flag_Z0", 32'(z0), 32'(mz0));
      check("flag_C0", 32'(c0), 32'(mc0));
      check("flag_Z1", 32'(z1), 32'(mz1));
      check("flag_C1", 32'(c1), 32'(mc1));
      check("post_A0", 32'(out_A0), 32'(rd0(na)));
      check("post_B1", 32'(out_B1), 32'(rd1(nb)));
      $display("t=%0t rst=%0d wr=%0d nr=%0d tryb=%0d dane=%02h A0=%02h B0=%02h A1=%02h B1=%02h Z0=%0d C0=%0d Z1=%0d C1=%0d",
               $time, rv, wv, nr, t, d & 255, out_A0, out_B0, out_A1, out_B1, z0, c0, z1, c1);
   endtask

   initial begin
      rst = 1'b1; wr_Rx = 1'b0; nr_Rx = '0; tryb = '0; dane = '0; nr_A = '0; nr_B = '0;
      foreach (m0[i]) m0[i] = 0;
      foreach (m1[i]) m1[i] = 0;
      mz0 = 0; mc0 = 0; mz1 = 0; mc1 = 0;
      // Two cycles of reset bring the DUT from power-up X into a known state
      repeat (2) @(posedge clk);
      #1;
      check("reset_Z", 32'(z0), 32'd0);
      check("reset_C", 32'(c0), 32'd0);

      // Reset then load R3 = F0
      step(0, 1, 3, 0, 8'hF0, 3, 4);
      check("load_R3", 32'(out_A0), 32'hF0);
      step(0, 0, 0, 0, 0, 0, 7);

      // Increment wraps from FF to 00 with carry, then counts to 01 with no carry
      step(0, 1, 5, 0, 8'hFF, 5, 5);
      step(0, 1, 5, 1, 0, 5, 5);
      check("inc_wrap_C", 32'(c0), 32'd1);
      check("inc_wrap_val", 32'(out_A0), 32'h00);
      step(0, 1, 5, 1, 0, 5, 5);
      check("inc_again", 32'(out_A0), 32'h01);

      // Decrement of zero borrows; clear sets Z
      step(0, 1, 2, 2, 0, 2, 2);
      check("dec_borrow_val", 32'(out_A0), 32'hFF);
      check("dec_borrow_C", 32'(c0), 32'd1);
      step(0, 1, 2, 3, 0, 2, 2);
      check("clear_Z", 32'(z0), 32'd1);

      // Dual read with no same-cycle bypass
      step(0, 1, 1, 0, 8'h11, 1, 1);
      step(0, 1, 6, 0, 8'h66, 6, 1);
      check("no_bypass_next", 32'(out_A0), 32'h66);

      // Reset wins over a write in the same cycle
      step(1, 1, 4, 0, 8'hAA, 4, 5);
      check("rst_collision_R4", 32'(out_A0), 32'h00);

      // Hardwired R0 and out-of-range destination on the 6-register build
      step(0, 1, 3, 1, 0, 3, 0);
      step(0, 1, 0, 0, 8'h55, 0, 7);
      check("zr0_flagZ_hold", 32'(z1), 32'd0);
      check("zr0_read", 32'(out_A1), 32'h00);
      step(0, 1, 7, 0, 8'h77, 7, 0);
      check("oor_read", 32'(out_A1), 32'h00);
      check("oor_flagC_hold", 32'(c1), 32'd0);

      // Randomized operations against the model
      for (int k = 0; k < 300; k++) begin
         step(($urandom_range(0, 39) == 0) ? 1 : 0,
              ($urandom_range(0, 3) != 0) ? 1 : 0,
              $urandom_range(0, 7), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255),
              $urandom_range(0, 7), $urandom_range(0, 7));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rejestry_alu.md
REJESTRY_ALU -- requirements
Module: rejestry_alu

Interface
REQ-001 SHALL have parameter Rx_liczba, default 8: number of registers, legal range 2..256.
REQ-002 SHALL have parameter SZER, default 8: register and data width in bits, legal range 1..32.
REQ-003 SHALL have parameter ZERO_R0, default 0: when 1, R0 is hardwired to zero.
REQ-004 SHALL define AW = ceil(log2(Rx_liczba)), minimum 1, as the width of every register-number port.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wr_Rx  input  1  write/operation strobe, sampled on the rising edge of clk.
REQ-008 nr_Rx  input  AW  destination register number.
REQ-009 tryb  input  2  operation: 00 load dane, 01 increment, 10 decrement, 11 clear.
REQ-010 dane  input  SZER  load data.
REQ-011 nr_A  input  AW  read port A register number.
REQ-012 nr_B  input  AW  read port B register number.
REQ-013 out_A  output  SZER  read port A data.
REQ-014 out_B  output  SZER  read port B data.
REQ-015 flaga_Z  output  1  zero flag of the last executed operation.
REQ-016 flaga_C  output  1  carry/borrow flag of the last executed operation.

Function
REQ-017 SHALL hold Rx_liczba registers R0..R(Rx_liczba-1), each SZER bits wide.
REQ-018 SHALL drive out_A and out_B combinationally: out_A = R[nr_A] and out_B = R[nr_B], with no clock latency.
REQ-019 SHALL make a write visible on out_A/out_B from the cycle after the wr_Rx edge; no same-cycle bypass.
REQ-020 SHALL, when wr_Rx=1 at a clock edge, compute a result from tryb and R[nr_Rx], and write it to R[nr_Rx].
- load: result = dane, C = 0.
- increment: result = R+1 modulo 2^SZER, C = 1 only when R was all-ones.
- decrement: result = R-1 modulo 2^SZER, C = 1 only when R was zero (borrow).
- clear: result = 0, C = 0.
REQ-021 SHALL, on every executed operation, update flaga_Z = (result == 0) and flaga_C as defined in REQ-020, registered in the same edge as the write.
REQ-022 SHALL hold all registers and both flags unchanged when wr_Rx=0.
REQ-023 SHALL let both read ports address the same register and return identical data.
REQ-024 SHALL, when ZERO_R0=1, read R0 as 0 on both ports, ignore operations targeting R0, and leave both flags unchanged for them.
REQ-025 SHALL, when nr_Rx >= Rx_liczba, ignore the operation and leave both flags unchanged.
REQ-026 SHALL return 0 on a read port whose number is >= Rx_liczba.
REQ-027 SHALL keep read ports functional during a write; a read of the destination returns the old value until the next edge.

Reset
REQ-028 SHALL, on a rising edge with rst=1, clear all registers, flaga_Z and flaga_C to 0.
REQ-029 SHALL give rst priority over wr_Rx in the same cycle; no operation executes and no flag updates.
REQ-030 SHALL drive out_A = out_B = 0 from the first edge after rst is sampled high until the next write.
REQ-031 SHALL resume normal operation on the first edge with rst=0, including a write on that edge.

Verification
REQ-032 Reset then load: rst for 2 cycles, then wr_Rx=1, tryb=00, nr_Rx=3, dane=8'hF0 -> next cycle R3=F0, out_A(nr_A=3)=F0, Z=0, C=0; other registers read 0.
REQ-033 Increment wrap: load R5=8'hFF, then increment R5 -> R5=00, Z=1, C=1; increment again -> R5=01, Z=0, C=0.
REQ-034 Decrement borrow: decrement R2=00 -> R2=FF, Z=0, C=1; clear R2 -> R2=00, Z=1, C=0.
REQ-035 Dual read and no bypass: load R1=8'h11, then in one cycle load R6=8'h66 with nr_A=6, nr_B=1 -> that cycle out_A=00, out_B=11; next cycle out_A=66.
REQ-036 Reset collision: rst=1 and wr_Rx=1 (load R4=8'hAA) in the same cycle -> R4=00, Z=0, C=0.
REQ-037 ZERO_R0=1 build with Rx_liczba=6: load R0=8'h55 and load nr_Rx=7 -> both ignored, flags unchanged, out_A(nr_A=0)=00 and out_A(nr_A=7)=00.
